mult_seq_ctrl: RTL and testbench
================================

# mult_seq_ctrl

Multi-cycle sequencer for the KGP_RISC combinational 32x32 unsigned multiplier. Accepts MULT/MULTU requests from the execute stage and applies magnitude operands to the multiplier for a fixed settle window. It then captures the 64-bit product, sign-corrected, into architectural HI/LO registers. It interlocks HI/LO reads against an in-flight multiply. Sits between the ALU decode/execute stage and the multiplier instance.

## Interface
Parameters:
- WIDTH, 32: operand width; product is 2*WIDTH.
- WAIT_CYCLES, 4: settle cycles granted to the combinational multiplier; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request a multiply; sampled only when idle.
- is_signed  in  1  1 = MULT (two's complement), 0 = MULTU; sampled with start.
- op_a  in  WIDTH  multiplicand; sampled with start.
- op_b  in  WIDTH  multiplier; sampled with start.
- flush  in  1  abort the in-flight multiply.
- hi_lo_rd  in  1  execute stage is reading HI or LO this cycle.
- mul_a  out  WIDTH  registered operand to the multiplier (inp1).
- mul_b  out  WIDTH  registered operand to the multiplier (inp2).
- mul_p  in  2*WIDTH  product from the multiplier (result).
- busy  out  1  multiply in flight.
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- stall  out  1  freeze the pipeline.
- hi  out  WIDTH  upper product half.
- lo  out  WIDTH  lower product half.

## Operation
- FSM has two states: IDLE and WAIT.
- IDLE with start=1 and flush=0:
  - mul_a <= |op_a| and mul_b <= |op_b| when is_signed=1; raw op_a and op_b otherwise.
  - neg <= is_signed & (op_a[MSB] ^ op_b[MSB]).
  - cnt <= WAIT_CYCLES-1.
  - Next state WAIT.
- Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1). It fits unsigned in WIDTH bits, so no overflow path is needed.
- WAIT, cnt != 0: cnt decrements each cycle. mul_a/mul_b hold.
- WAIT, cnt == 0:
  - {hi,lo} <= neg ? (~mul_p + 1) : mul_p, using full 2*WIDTH negation.
  - done <= 1.
  - Next state IDLE.
- flush=1 in WAIT: next state IDLE. HI/LO unchanged, no done.
- flush=1 in IDLE: start is ignored.
- start=1 in WAIT is ignored. The pipeline is held by stall, and the requester re-presents start after busy drops.
- busy = (state == WAIT), combinational from state.
- stall = hi_lo_rd & (busy | start), combinational. A read in the same cycle as start also stalls, so it returns the new result.
- mul_a and mul_b change only on an accepted start. The multiplier inputs are stable for the entire window.

## Timing
- Reset values: state IDLE, cnt 0, neg 0, mul_a 0, mul_b 0, hi 0, lo 0, done 0. busy and stall are 0 with inputs idle.
- rst overrides everything, including mid-WAIT. No done is produced for the aborted operation.
- Let cycle 0 be the cycle where start is accepted in IDLE.
  - Cycles 1..WAIT_CYCLES: busy=1.
  - Edge ending cycle WAIT_CYCLES: HI/LO are written.
  - Cycle WAIT_CYCLES+1: done=1 and busy=0, and HI/LO show the new value.
- Result latency is WAIT_CYCLES+1 cycles from start.
- A new start is accepted in the done cycle, so the maximum throughput is one multiply per WAIT_CYCLES+1 cycles.
- The multiplier path is a multicycle path of WAIT_CYCLES from mul_a/mul_b to HI/LO, and is constrained as such.
- done is registered and glitch-free. Exactly one done pulse is produced per non-aborted start.
- flush in the same cycle that cnt reaches 0: flush wins, and there is no HI/LO write.

## Test plan
- Reset, then MULTU 0xFFFFFFFF x 0xFFFFFFFF with WAIT_CYCLES=4 -> busy high for cycles 1-4, done in cycle 5, hi=0xFFFFFFFE, lo=0x00000001.
- MULT -7 x 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Same operands as MULTU -> hi=0x00000002, lo=0xFFFFFFEB.
- MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0. MULT 0x80000000 x 1 -> hi=0xFFFFFFFF, lo=0x80000000.
- hi_lo_rd asserted in cycles 0-5 around a multiply -> stall=1 in cycles 0-4 and 0 in cycle 5. Read in cycle 5 returns the new result.
- Multiply 5x5, then flush in cycle 2 -> no done, HI/LO keep the previous value. A start in the cycle after the flush is accepted normally.
- Back-to-back: start held high, with 2x3 then 4x5 -> done in cycles 5 and 10, results 6 then 20. Also assert rst mid-WAIT -> all outputs return to reset values next cycle, and no done.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the KGP_RISC 32x32 combinational multiplier: holds magnitude
// operands steady for a fixed settle window, then captures the sign-corrected product into HI/LO.
module mult_seq_ctrl #(
  parameter int WIDTH       = 32,
  parameter int WAIT_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               flush,
  input  logic               hi_lo_rd,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_p,
  output logic               busy,
  output logic               done,
  output logic               stall,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  logic [0:0]         state;
  logic [3:0]         cnt;
  logic               neg;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH-1:0] prod_fix;

  // The magnitude of the most negative value still fits as an unsigned WIDTH-bit number.
  always_comb begin
    abs_a = op_a;
    abs_b = op_b;
    if (is_signed && op_a[WIDTH-1]) abs_a = ~op_a + 1'b1;
    if (is_signed && op_b[WIDTH-1]) abs_b = ~op_b + 1'b1;
  end

  always_comb begin
    prod_fix = mul_p;
    if (neg) prod_fix = ~mul_p + 1'b1;
  end

  assign busy  = (state == WAIT);
  assign stall = hi_lo_rd & (busy | start);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      neg   <= 1'b0;
      mul_a <= '0;
      mul_b <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            mul_a <= abs_a;
            mul_b <= abs_b;
            neg   <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            cnt   <= CNT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          // Flush has priority even on the capture cycle.
          if (flush) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            {hi, lo} <= prod_fix;
            done     <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: expected products are queued on each accepted start
// and a monitor pops them on every done pulse.
module tb_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        hi_lo_rd;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_p;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  // Stand-in for the combinational multiplier instance.
  assign mul_p = {32'b0, mul_a} * {32'b0, mul_b};

  mult_seq_ctrl #(.WIDTH(32), .WAIT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .flush(flush), .hi_lo_rd(hi_lo_rd),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done act=%h exp=none t=%0t", {hi, lo}, $time);
      end else begin
        chk("sb_result", {hi, lo}, sb.pop_front());
      end
    end
  end

  // Start in cycle 0, check busy in cycles 1-4 and the result in cycle 5; leaves the bench in cycle 5.
  task automatic do_mul(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    start = 1'b1; is_signed = s; op_a = a; op_b = b;
    sb.push_back(exp);
    tick();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("busy_window", {63'b0, busy}, 64'd1);
      tick();
    end
    chk("done_cycle5", {63'b0, done}, 64'd1);
    chk("busy_cycle5", {63'b0, busy}, 64'd0);
    chk("hilo_cycle5", {hi, lo}, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    flush = 1'b0; hi_lo_rd = 1'b0;
    tick(); tick();
    chk("reset_outs", {busy, done, stall, 61'b0}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_mul", {mul_a, mul_b}, 64'd0);
    rst = 1'b0;
    tick();

    do_mul(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    tick();
    do_mul(1'b1, 32'hFFFFFFF9, 32'd3, 64'hFFFFFFFF_FFFFFFEB);
    tick();
    do_mul(1'b0, 32'hFFFFFFF9, 32'd3, 64'h00000002_FFFFFFEB);
    tick();
    do_mul(1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
    tick();
    do_mul(1'b1, 32'h80000000, 32'd1, 64'hFFFFFFFF_80000000);
    chk("mag_mul_a", {32'b0, mul_a}, 64'h80000000);
    tick();

    // Interlock: read held across cycles 0-5 of a multiply.
    hi_lo_rd = 1'b1;
    start = 1'b1; is_signed = 1'b1; op_a = 32'd6; op_b = 32'hFFFFFFFF;
    sb.push_back(64'hFFFFFFFF_FFFFFFFA);
    #1 chk("stall_c0", {63'b0, stall}, 64'd1);
    tick();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1 chk("stall_c1to4", {63'b0, stall}, 64'd1);
      tick();
    end
    #1 chk("stall_c5", {63'b0, stall}, 64'd0);
    chk("read_c5", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
    hi_lo_rd = 1'b0;
    tick();

    // Flush in cycle 2, then restart in cycle 3.
    start = 1'b1; is_signed = 1'b0; op_a = 32'd5; op_b = 32'd5;
    tick(); start = 1'b0;
    tick(); flush = 1'b1;
    tick(); flush = 1'b0;
    chk("flush_idle", {63'b0, busy}, 64'd0);
    chk("flush_keep", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
    do_mul(1'b0, 32'd5, 32'd5, 64'd25);
    tick();

    // Flush coinciding with the capture cycle (cycle 4).
    start = 1'b1; is_signed = 1'b0; op_a = 32'd9; op_b = 32'd9;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    flush = 1'b1;
    tick(); flush = 1'b0;
    chk("flush_last_done", {63'b0, done}, 64'd0);
    chk("flush_last_keep", {hi, lo}, 64'd25);
    tick();

    // Back-to-back with start held high.
    start = 1'b1; is_signed = 1'b0; op_a = 32'd2; op_b = 32'd3;
    sb.push_back(64'd6);
    sb.push_back(64'd20);
    tick();
    op_a = 32'd4; op_b = 32'd5;
    chk("b2b_hold_a", {32'b0, mul_a}, 64'd2);
    tick(); tick(); tick(); tick();
    chk("b2b_done5", {63'b0, done}, 64'd1);
    chk("b2b_res1", {hi, lo}, 64'd6);
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("b2b_done10", {63'b0, done}, 64'd1);
    chk("b2b_res2", {hi, lo}, 64'd20);
    tick();

    // Reset mid-WAIT.
    start = 1'b1; is_signed = 1'b1; op_a = 32'd7; op_b = 32'd7;
    tick(); start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_outs", {busy, done, stall, 61'b0}, 64'd0);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    chk("rst_mid_mul", {mul_a, mul_b}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
